// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enable writes, registered reads and a post-reset clear sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WR_BYPASS_EN.
//
// state | meaning
// CLEAR | zeroing one register per cycle; reads forced to 0, writes dropped
// RUN   | normal operation; ready=1

module register_file_mp #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 0,
    localparam int AW = $clog2(NUM_REGS),
    localparam int BW = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD-1:0]            read_en,
    input  logic [NUM_RD*AW-1:0]         raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic                         write_en,
    input  logic [AW-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [BW-1:0]                wbe,
    output logic                         ready,
    output logic                         wr_drop
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW:0]   NREGS_EXT = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    state_t                         state_q, state_d;
    logic [AW-1:0]                  clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]          regs_d [NUM_REGS];
    logic [NUM_RD*DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                           ready_q, ready_d;
    logic                           wr_drop_q, wr_drop_d;

    logic                           wr_acc;
    logic [DATA_WIDTH-1:0]          wr_word;
    logic [AW-1:0]                  ra;
    logic [DATA_WIDTH-1:0]          rd_word;

    // Address is backed by storage and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < NREGS_EXT);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BW-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        regs_d    = regs_q;
        rdata_d   = rdata_q;
        wr_drop_d = 1'b0;
        ra        = '0;
        rd_word   = '0;
        wr_acc    = (state_q == RUN) && write_en && addr_ok(waddr);
        wr_word   = wr_acc ? merge_bytes(regs_q[waddr], wdata, wbe) : '0;

        case (state_q)
            CLEAR: begin
                regs_d[clr_cnt_q] = '0;
                clr_cnt_d         = clr_cnt_q + AW'(1);
                rdata_d           = '0;
                wr_drop_d         = write_en;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                if (wr_acc) begin
                    regs_d[waddr] = wr_word;
                end else if (write_en) begin
                    wr_drop_d = 1'b1;
                end
                for (int k = 0; k < NUM_RD; k++) begin
                    if (read_en[k]) begin
                        ra = raddr[k*AW +: AW];
                        if (addr_ok(ra)) begin
                            rd_word = regs_q[ra];
                            // Only accepted writes are forwarded, so ignored writes never leak out.
                            if (BYPASS && wr_acc && (ra == waddr)) begin
                                rd_word = wr_word;
                            end
                        end else begin
                            rd_word = '0;
                        end
                        rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_word;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        ready_d = (state_d == RUN);
    end

    // Contents are not touched by reset; the CLEAR sequence zeroes them afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
            regs_q    <= regs_d;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default instance plus a 12-entry, zero-register, single-port instance.
// Expectations for the same-cycle read follow REGFILE_WR_BYPASS_EN as compiled.

module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  read_en;
    logic [7:0]  raddr;
    logic [63:0] rdata;
    logic        write_en;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        ready;
    logic        wr_drop;

    logic        b_reset;
    logic [0:0]  b_read_en;
    logic [3:0]  b_raddr;
    logic [31:0] b_rdata;
    logic        b_write_en;
    logic [3:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wbe;
    logic        b_ready;
    logic        b_wr_drop;

    register_file_mp dut (
        .clk      (clk),
        .reset    (reset),
        .read_en  (read_en),
        .raddr    (raddr),
        .rdata    (rdata),
        .write_en (write_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbe      (wbe),
        .ready    (ready),
        .wr_drop  (wr_drop)
    );

    register_file_mp #(
        .NUM_REGS   (12),
        .DATA_WIDTH (32),
        .NUM_RD     (1),
        .ZERO_REG   (1)
    ) dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .read_en  (b_read_en),
        .raddr    (b_raddr),
        .rdata    (b_rdata),
        .write_en (b_write_en),
        .waddr    (b_waddr),
        .wdata    (b_wdata),
        .wbe      (b_wbe),
        .ready    (b_ready),
        .wr_drop  (b_wr_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        write_en = 1'b1;
        waddr    = a;
        wdata    = d;
        wbe      = be;
        step();
        write_en = 1'b0;
    endtask

    task automatic rd_a(input logic [1:0] mask, input logic [3:0] a0, input logic [3:0] a1);
        read_en = mask;
        raddr   = {a1, a0};
        step();
        read_en = 2'b00;
    endtask

    logic [31:0] exp_p0, exp_p1, v;
    logic [1:0]  mask;

    initial begin
        reset = 1'b1; read_en = '0; raddr = '0; write_en = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        b_reset = 1'b1; b_read_en = '0; b_raddr = '0; b_write_en = 1'b0; b_waddr = '0; b_wdata = '0; b_wbe = '0;
        exp_p0 = '0; exp_p1 = '0;

        step();
        step();
        check_val("rst_ready", {63'd0, ready}, 64'd0);
        check_val("rst_rdata", rdata, 64'd0);
        check_val("rst_wr_drop", {63'd0, wr_drop}, 64'd0);

        // Release; reads enabled and one write attempted during CLEAR.
        reset   = 1'b0;
        read_en = 2'b11;
        raddr   = 8'h95;
        for (int i = 1; i <= 16; i++) begin
            write_en = (i == 5);
            waddr    = 4'd2;
            wdata    = 32'hFFFF_FFFF;
            wbe      = 4'hF;
            step();
            check_val("clr_ready", {63'd0, ready}, {63'd0, (i == 16)});
            check_val("clr_rdata", rdata, 64'd0);
            if (i == 5) check_val("clr_drop_hi", {63'd0, wr_drop}, 64'd1);
            if (i == 6) check_val("clr_drop_lo", {63'd0, wr_drop}, 64'd0);
        end
        write_en = 1'b0;
        read_en  = 2'b00;

        for (int r = 0; r < 16; r++) begin
            rd_a(2'b11, 4'(r), 4'(15 - r));
            check_val("init_read", rdata, 64'd0);
        end

        // Walking 1 then walking 0 through every bit of every register.
        for (int r = 0; r < 16; r++) begin
            for (int pat = 0; pat < 2; pat++) begin
                for (int b = 0; b < 32; b++) begin
                    v = 32'h1 << b;
                    if (pat == 1) v = ~v;
                    wr_a(4'(r), v, 4'hF);
                    mask = (b % 3 == 0) ? 2'b01 : ((b % 3 == 1) ? 2'b10 : 2'b11);
                    rd_a(mask, 4'(r), 4'(r));
                    if (mask[0]) exp_p0 = v;
                    if (mask[1]) exp_p1 = v;
                    check_val("walk", rdata, {exp_p1, exp_p0});
                end
            end
        end

        wr_a(4'd5, 32'hAABB_CCDD, 4'hF);
        wr_a(4'd5, 32'h1122_3344, 4'b0101);
        check_val("be_no_drop", {63'd0, wr_drop}, 64'd0);
        rd_a(2'b11, 4'd5, 4'd5);
        check_val("byte_en", rdata, {32'hAA22_CC44, 32'hAA22_CC44});

        write_en = 1'b1; waddr = 4'd5; wdata = 32'h0; wbe = 4'h0;
        step();
        write_en = 1'b0;
        check_val("wbe0_no_drop", {63'd0, wr_drop}, 64'd0);
        rd_a(2'b01, 4'd5, 4'd0);
        check_val("wbe0_hold", {32'd0, rdata[31:0]}, {32'd0, 32'hAA22_CC44});

        // Same-cycle write and read of reg 3.
        wr_a(4'd3, 32'h0, 4'hF);
        write_en = 1'b1; waddr = 4'd3; wdata = 32'h1234_5678; wbe = 4'hF;
        read_en = 2'b01; raddr = 8'h03;
        step();
        write_en = 1'b0; read_en = 2'b00;
`ifdef REGFILE_WR_BYPASS_EN
        check_val("same_cyc", {32'd0, rdata[31:0]}, {32'd0, 32'h1234_5678});
`else
        check_val("same_cyc", {32'd0, rdata[31:0]}, 64'd0);
`endif
        rd_a(2'b01, 4'd3, 4'd0);
        check_val("after_wr", {32'd0, rdata[31:0]}, {32'd0, 32'h1234_5678});

        write_en = 1'b1; waddr = 4'd3; wdata = 32'hAAAA_BBBB; wbe = 4'b0011;
        read_en = 2'b10; raddr = 8'h30;
        step();
        write_en = 1'b0; read_en = 2'b00;
`ifdef REGFILE_WR_BYPASS_EN
        check_val("same_cyc_be", {32'd0, rdata[63:32]}, {32'd0, 32'h1234_BBBB});
`else
        check_val("same_cyc_be", {32'd0, rdata[63:32]}, {32'd0, 32'h1234_5678});
`endif
        rd_a(2'b10, 4'd0, 4'd3);
        check_val("after_wr_be", {32'd0, rdata[63:32]}, {32'd0, 32'h1234_BBBB});

        // Hold with read_en low while the source register changes.
        rd_a(2'b11, 4'd5, 4'd3);
        check_val("hold_base", rdata, {32'h1234_BBBB, 32'hAA22_CC44});
        for (int i = 0; i < 5; i++) begin
            write_en = (i == 0); waddr = 4'd5; wdata = 32'hDEAD_BEEF; wbe = 4'hF;
            raddr = 8'h77;
            step();
            check_val("hold", rdata, {32'h1234_BBBB, 32'hAA22_CC44});
        end
        write_en = 1'b0;
        rd_a(2'b01, 4'd5, 4'd0);
        check_val("hold_wr_landed", {32'd0, rdata[31:0]}, {32'd0, 32'hDEAD_BEEF});

        // Reset with an in-flight write, then reset again at clear cycle 7.
        reset = 1'b1; write_en = 1'b1; waddr = 4'd6; wdata = 32'hFFFF_FFFF; wbe = 4'hF;
        step();
        write_en = 1'b0;
        step();
        check_val("rst2_rdata", rdata, 64'd0);
        check_val("rst2_drop", {63'd0, wr_drop}, 64'd0);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            check_val("mid_ready", {63'd0, ready}, 64'd0);
        end
        reset = 1'b1; write_en = 1'b1; waddr = 4'd9;
        step();
        reset = 1'b0; write_en = 1'b0;
        check_val("mid_rst_ready", {63'd0, ready}, 64'd0);
        check_val("mid_rst_drop", {63'd0, wr_drop}, 64'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check_val("reclr_ready", {63'd0, ready}, {63'd0, (i == 16)});
        end
        rd_a(2'b11, 4'd5, 4'd6);
        check_val("reclr_read", rdata, 64'd0);
        rd_a(2'b11, 4'd3, 4'd9);
        check_val("reclr_read2", rdata, 64'd0);

        // Second instance: 12 entries, register 0 hard-wired.
        step();
        step();
        b_reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check_val("b_ready", {63'd0, b_ready}, {63'd0, (i == 12)});
        end
        b_write_en = 1'b1; b_waddr = 4'd11; b_wdata = 32'hCAFE_F00D; b_wbe = 4'hF;
        step();
        b_write_en = 1'b0;
        check_val("b_wr11_drop", {63'd0, b_wr_drop}, 64'd0);
        b_read_en = 1'b1; b_raddr = 4'd11;
        step();
        check_val("b_rd11", {32'd0, b_rdata}, {32'd0, 32'hCAFE_F00D});
        b_raddr = 4'd13;
        step();
        b_read_en = 1'b0;
        check_val("b_rd13", {32'd0, b_rdata}, 64'd0);

        b_write_en = 1'b1; b_waddr = 4'd13; b_wdata = 32'h1111_1111;
        step();
        b_write_en = 1'b0;
        check_val("b_wr13_drop", {63'd0, b_wr_drop}, 64'd1);
        step();
        check_val("b_drop_pulse", {63'd0, b_wr_drop}, 64'd0);

        b_write_en = 1'b1; b_waddr = 4'd12; b_wdata = 32'h2222_2222;
        step();
        b_write_en = 1'b0;
        check_val("b_wr12_drop", {63'd0, b_wr_drop}, 64'd1);

        b_write_en = 1'b1; b_waddr = 4'd0; b_wdata = 32'hFFFF_FFFF;
        step();
        b_write_en = 1'b0;
        check_val("b_wr0_drop", {63'd0, b_wr_drop}, 64'd1);
        b_read_en = 1'b1; b_raddr = 4'd11;
        step();
        check_val("b_rd11_again", {32'd0, b_rdata}, {32'd0, 32'hCAFE_F00D});
        b_raddr = 4'd0;
        step();
        b_read_en = 1'b0;
        check_val("b_rd0", {32'd0, b_rdata}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
